result_mag_pipe: RTL and testbench

Registered, parametrised successor to the combinational result-magnitude converter in the black-jack datapath. Takes a W-bit two's-complement score difference (player minus dealer) through a valid/ready handshake and returns sign, magnitude and zero flags. Optionally also returns BCD digits for the seven-segment result display, computed by a multi-cycle double-dabble engine. Sits between the score comparator and the display driver.

---
 rtl/result_mag_pipe.sv | 169 ++++++++++++++++
 tb/tb_result_mag_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_mag_pipe.sv
// result_mag_pipe
//
// Registered sign / magnitude / zero converter for the black-jack score
// difference (player minus dealer), with an optional BCD conversion for the
// seven-segment result display. Sits between the score comparator and the
// display driver.
//
// Build option:
//   RESULT_MAG_PIPE_BCD_EN  defined     -> multi-cycle double-dabble FSM,
//                                          bcd/bcd_ovf live, latency W cycles
//                           not defined -> single output register, latency 1,
//                                          bcd/bcd_ovf tied to 0
//
// Parameters:
//   W       raw_result width (>= 2)
//   DIGITS  number of BCD digits on bcd
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    raw_result is valid
//   in_ready    block can accept (transfer on in_valid && in_ready)
//   raw_result  W-bit two's-complement input
//   out_valid   result registers hold a valid result
//   out_ready   consumer takes the result (retire on out_valid && out_ready)
//   sign        1 iff raw_result < 0
//   mag_result  |raw_result|, unsigned (covers -2^(W-1))
//   zero        raw_result == 0
//   bcd         BCD of mag_result, digit 0 in bits [3:0]
//   bcd_ovf     mag_result does not fit in DIGITS digits
//
// FSM (BCD build only):
//   state | meaning
//   IDLE  | empty, ready for a new input
//   CONV  | double-dabble running, one bit per cycle
//   DONE  | result valid, waiting for the consumer
module result_mag_pipe #(
  parameter int W      = 6,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        raw_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign,
  output logic [W-1:0]        mag_result,
  output logic                zero,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_ovf
);

  logic         in_sign;
  logic [W-1:0] in_mag;
  logic         in_zero;
  logic         xfer;

  // -2^(W-1) negates to itself, which read as unsigned is the right magnitude
  assign in_sign = raw_result[W-1];
  assign in_mag  = in_sign ? (~raw_result + 1'b1) : raw_result;
  assign in_zero = (raw_result == '0);
  assign xfer    = in_valid && in_ready;

`ifdef RESULT_MAG_PIPE_BCD_EN

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + W;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SH_W-1:0]  sh;
  logic [SH_W-1:0]  sh_adj;
  logic [CNT_W-1:0] cnt;
  logic             step;

  // add-3 correction on every BCD digit before the shift
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh[W+4*i +: 4] >= 4'd5) begin
        sh_adj[W+4*i +: 4] = sh[W+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      cnt        <= '0;
      bcd_ovf    <= 1'b0;
      sign       <= 1'b0;
      mag_result <= '0;
      zero       <= 1'b0;
    end else if (xfer) begin
      sh         <= {{BCD_W{1'b0}}, in_mag};
      cnt        <= CNT_W'(W);
      bcd_ovf    <= 1'b0;
      sign       <= in_sign;
      mag_result <= in_mag;
      zero       <= in_zero;
    end else if (step) begin
      sh      <= {sh_adj[SH_W-2:0], 1'b0};
      cnt     <= cnt - 1'b1;
      // anything leaving the top digit is a lost 10^DIGITS carry
      bcd_ovf <= bcd_ovf | sh_adj[SH_W-1];
    end
  end

  assign bcd = sh[SH_W-1 -: BCD_W];

`else

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      sign       <= 1'b0;
      mag_result <= '0;
      zero       <= 1'b0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      sign       <= in_sign;
      mag_result <= in_mag;
      zero       <= in_zero;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign bcd     = '0;
  assign bcd_ovf = 1'b0;

`endif

endmodule

// File: tb/tb_result_mag_pipe.sv
// Testbench for result_mag_pipe: directed vectors with literal expectations
// plus a transaction-level model checked on every cycle.
module tb_result_mag_pipe;

  localparam int W      = 6;
  localparam int DIGITS = 2;
`ifdef RESULT_MAG_PIPE_BCD_EN
  localparam bit BCD_ON = 1'b1;
  localparam int OFF    = W;   // cycles after the transfer edge
`else
  localparam bit BCD_ON = 1'b0;
  localparam int OFF    = 0;
`endif

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        raw_result;
  logic                out_valid;
  logic                out_ready;
  logic                sign;
  logic [W-1:0]        mag_result;
  logic                zero;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_ovf;

  logic         in_valid1, in_ready1, out_valid1, sign1, zero1, bcd_ovf1;
  logic [W-1:0] raw1, mag1;
  logic [3:0]   bcd1;

  result_mag_pipe #(.W(W), .DIGITS(DIGITS)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .raw_result(raw_result), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .mag_result(mag_result), .zero(zero), .bcd(bcd),
    .bcd_ovf(bcd_ovf)
  );

  result_mag_pipe #(.W(W), .DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .raw_result(raw1), .out_valid(out_valid1), .out_ready(1'b1),
    .sign(sign1), .mag_result(mag1), .zero(zero1), .bcd(bcd1),
    .bcd_ovf(bcd_ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out actual=none required=event (t=%0t)", name, $time);
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] m_bcd(input int m, input int nd);
    logic [31:0] res;
    int x;
    res = '0;
    x = m;
    for (int i = 0; i < nd; i++) begin
      res = res | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return res;
  endfunction

  function automatic logic m_ovf(input int m, input int nd);
    int p;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return (m >= p);
  endfunction

  typedef struct {
    logic [W-1:0] raw;
    int           t;
  } item_t;

  item_t q[$];
  bit    ev_m;
  bit    eir_m;
  int    v_m;
  int    m_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_outputs", 32'({out_valid, sign, zero, bcd_ovf, mag_result, bcd}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      ev_m  = (q.size() > 0) ? (cyc >= q[0].t + OFF) : 1'b0;
      eir_m = (q.size() == 0) ? 1'b1 : (ev_m ? out_ready : 1'b0);
      chk("out_valid", 32'(out_valid), 32'(ev_m));
      chk("in_ready", 32'(in_ready), 32'(eir_m));
      if (ev_m) begin
        v_m = int'($signed(q[0].raw));
        m_m = (v_m < 0) ? -v_m : v_m;
        chk("sign", 32'(sign), 32'(v_m < 0));
        chk("mag", 32'(mag_result), 32'(m_m));
        chk("zero", 32'(zero), 32'(v_m == 0));
        chk("bcd", 32'(bcd), BCD_ON ? m_bcd(m_m, DIGITS) : 32'd0);
        chk("bcd_ovf", 32'(bcd_ovf), BCD_ON ? 32'(m_ovf(m_m, DIGITS)) : 32'd0);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back('{raw_result, cyc + 1});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [W-1:0] r);
    int n;
    n = 0;
    in_valid   = 1'b1;
    raw_result = r;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout("send");
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 200) begin
        timeout("wait_valid");
        break;
      end
    end
  endtask

  int           n;
  bit           sweep_done;
  logic [W-1:0] tv [3];
  logic         rs [3];
  logic [W-1:0] rm [3];
  int           rc [3];
  logic [W-1:0] d1v [2];
  logic [3:0]   d1b [2];
  logic         d1o [2];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; raw_result = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; raw1 = '0;
    tv  = '{6'd5, 6'h3b, 6'd10};
    d1v = '{6'd15, 6'd9};
    d1b = '{4'h5, 4'h9};
    d1o = '{1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // -10
    send(6'h36);
    wait_valid(n);
    chk("neg_latency", 32'(n), 32'(OFF));
    chk("neg_sign", 32'(sign), 32'd1);
    chk("neg_mag", 32'(mag_result), 32'd10);
    chk("neg_zero", 32'(zero), 32'd0);
    chk("neg_bcd", 32'(bcd), BCD_ON ? 32'h10 : 32'h0);
    chk("neg_ovf", 32'(bcd_ovf), 32'd0);
    @(posedge clk); #1;

    send(6'h00);
    wait_valid(n);
    chk("zero_sign", 32'(sign), 32'd0);
    chk("zero_mag", 32'(mag_result), 32'd0);
    chk("zero_flag", 32'(zero), 32'd1);
    chk("zero_bcd", 32'(bcd), 32'h00);
    @(posedge clk); #1;

    // -32
    send(6'h20);
    wait_valid(n);
    chk("minneg_sign", 32'(sign), 32'd1);
    chk("minneg_mag", 32'(mag_result), 32'd32);
    chk("minneg_zero", 32'(zero), 32'd0);
    chk("minneg_bcd", 32'(bcd), BCD_ON ? 32'h32 : 32'h0);
    @(posedge clk); #1;

    // back-pressure: -7 held while +5 waits
    out_ready = 1'b0;
    send(6'h39);
    wait_valid(n);
    in_valid = 1'b1;
    raw_result = 6'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({sign, mag_result, bcd}), 32'({1'b1, 6'd7, BCD_ON ? 8'h07 : 8'h00}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(n);
    chk("bp_final_mag", 32'(mag_result), 32'd5);
    chk("bp_final_sign", 32'(sign), 32'd0);
    @(posedge clk); #1;

    // back-to-back +5, -5, +10
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int k;
          k = 0;
          in_valid = 1'b1;
          raw_result = tv[i];
          while (1) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
              timeout("thru_send");
              break;
            end
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        got = 0;
        for (int c = 0; c < 300 && got < 3; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            rs[got] = sign;
            rm[got] = mag_result;
            rc[got] = cyc;
            got++;
          end
        end
        if (got < 3) timeout("thru_collect");
      end
    join
    chk("thru0", 32'({rs[0], rm[0]}), 32'({1'b0, 6'd5}));
    chk("thru1", 32'({rs[1], rm[1]}), 32'({1'b1, 6'd5}));
    chk("thru2", 32'({rs[2], rm[2]}), 32'({1'b0, 6'd10}));
`ifndef RESULT_MAG_PIPE_BCD_EN
    chk("thru_consecutive", 32'(rc[2] - rc[0]), 32'd2);
`endif
    @(posedge clk); #1;

    // every input value, random consumer stalls
    sweep_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 64; v++) send(v[W-1:0]);
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;

    // reset two cycles after a transfer
    send(6'd9);
    @(posedge clk); #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_outputs", 32'({out_valid, sign, zero, bcd_ovf, mag_result, bcd}), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(6'h3d);
    wait_valid(n);
    chk("post_rst_latency", 32'(n), 32'(OFF));
    chk("post_rst_sign", 32'(sign), 32'd1);
    chk("post_rst_mag", 32'(mag_result), 32'd3);
    chk("post_rst_bcd", 32'(bcd), BCD_ON ? 32'h03 : 32'h0);
    @(posedge clk); #1;

    // single-digit instance: overflow boundary
    for (int i = 0; i < 2; i++) begin
      int k;
      in_valid1 = 1'b1;
      raw1 = d1v[i];
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      k = 0;
      while (1) begin
        @(negedge clk);
        if (out_valid1) break;
        k++;
        if (k > 200) begin
          timeout("d1_wait");
          break;
        end
      end
      chk("d1_mag", 32'(mag1), 32'(d1v[i]));
      chk("d1_bcd", 32'(bcd1), BCD_ON ? 32'(d1b[i]) : 32'd0);
      chk("d1_ovf", 32'(bcd_ovf1), BCD_ON ? 32'(d1o[i]) : 32'd0);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
